// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus write arbiter: FSM state encoding and
// the width of the strobe down-counter.
package bus_arb_pkg;

  // Transfer phases: waiting for a request, driving the strobe, and the
  // single cycle that carries the ack pulse and keeps the bus quiet.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Strobe length is held in a 4-bit down-counter, so at most 15 cycles.
  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: returns the first asserted request found
// scanning upward from i_pointer, wrapping around at NREQ.
// A pointer tied to zero turns this into plain lowest-index-first priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_pointer,
  output logic [PW-1:0]   o_winner,
  output logic            o_valid
);

  // First pass takes indices at or above the pointer; the second pass
  // wraps around to the low indices only if nothing was found yet.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!o_valid && i_req[j] && (j >= int'(i_pointer))) begin
        o_valid  = 1'b1;
        o_winner = PW'(j);
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!o_valid && i_req[j]) begin
        o_valid  = 1'b1;
        o_winner = PW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_write_arbiter.sv
// Bus write arbiter: grants one of NREQ requesters, drives its word on the
// shared q bus with a STROBE_CYCLES-long strobe, then pulses that
// requester's ack and leaves one idle bus cycle before the next grant.
// Build option: define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// without it the lowest asserted request index always wins.
module bus_write_arbiter
  import bus_arb_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int NREQ          = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [WIDTH-1:0]      q,
  output logic                  strobe,
  output logic [NREQ-1:0]       ack,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   w_qNext;
  logic               r_strobe;
  logic               w_strobeNext;
  logic [NREQ-1:0]    r_ack;
  logic [NREQ-1:0]    w_ackNext;
  logic [PW-1:0]      r_winner;
  logic [PW-1:0]      w_winnerNext;
  logic [PW-1:0]      w_pointer;
  logic [PW-1:0]      w_pick;
  logic               w_valid;
  logic               w_grant;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req     (req),
    .i_pointer (w_pointer),
    .o_winner  (w_pick),
    .o_valid   (w_valid)
  );

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] r_pointer;

  // Round-robin pointer moves to one past the winner on every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pointer <= '0;
    end else if (w_grant) begin
      r_pointer <= (int'(w_pick) == NREQ - 1) ? '0 : w_pick + 1'b1;
    end
  end

  assign w_pointer = r_pointer;
`else
  assign w_pointer = '0;
`endif

  // State and output registers; reset aborts any transfer without an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_q      <= '0;
      r_strobe <= 1'b0;
      r_ack    <= '0;
      r_winner <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_q      <= w_qNext;
      r_strobe <= w_strobeNext;
      r_ack    <= w_ackNext;
      r_winner <= w_winnerNext;
    end
  end

  // Next-state logic; requests and data are only looked at in IDLE, so a
  // transfer in flight is immune to anything the requesters do.
  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_qNext      = r_q;
    w_strobeNext = 1'b0;
    w_ackNext    = '0;
    w_winnerNext = r_winner;
    w_grant      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_grant      = 1'b1;
          w_stateNext  = STROBE;
          w_strobeNext = 1'b1;
          w_cntNext    = CNT_W'(STROBE_CYCLES - 1);
          w_winnerNext = w_pick;
          for (int k = 0; k < NREQ; k++) begin
            if (w_pick == PW'(k)) begin
              w_qNext = data[k*WIDTH +: WIDTH];
            end
          end
        end
      end
      STROBE: begin
        if (r_cnt == '0) begin
          w_stateNext = ACK;
          for (int k = 0; k < NREQ; k++) begin
            w_ackNext[k] = (r_winner == PW'(k));
          end
        end else begin
          w_strobeNext = 1'b1;
          w_cntNext    = r_cnt - 1'b1;
        end
      end
      ACK: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign q      = r_q;
  assign strobe = r_strobe;
  assign ack    = r_ack;
  assign busy   = (r_state != IDLE);

endmodule

// File: doc/bus_write_arbiter.md
BUS_WRITE_ARBITER -- requirements
Module: bus_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data word width.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 Parameter STROBE_CYCLES, default 2: number of cycles strobe is high per transfer, legal range 1..15.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous, active-high.
REQ-006 Port req, input, NREQ: per-requester level request; requester i holds req[i] and its data slice stable until ack[i].
REQ-007 Port data, input, NREQ*WIDTH: requester i's word in bits [i*WIDTH +: WIDTH].
REQ-008 Port q, output, WIDTH: registered shared output bus.
REQ-009 Port strobe, output, 1: registered write strobe qualifying q.
REQ-010 Port ack, output, NREQ: registered one-cycle completion pulse, one-hot or zero.
REQ-011 Port busy, output, 1: high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, STROBE and ACK.
REQ-013 In IDLE with req != 0 at edge N, the block SHALL select winner w, load q <= data slice w, set strobe=1 and enter STROBE, all visible after edge N.
REQ-014 In IDLE with req == 0, the block SHALL hold q and keep strobe=0 and ack=0.
REQ-015 strobe SHALL stay high for exactly STROBE_CYCLES consecutive cycles, counted by a 4-bit down-counter loaded at grant.
REQ-016 On the edge that ends the strobe, the block SHALL drive strobe=0, ack[w]=1 and enter ACK.
REQ-017 In ACK, the block SHALL return to IDLE on the next edge with ack=0; no grant is made in ACK, giving one idle bus cycle between transfers.
REQ-018 Latency from req sampled in IDLE to ack pulse SHALL be STROBE_CYCLES+1 cycles; transfer period back-to-back SHALL be STROBE_CYCLES+2 cycles.
REQ-019 q SHALL hold the granted word unchanged from grant until the next grant.
REQ-020 Changes of req or data after grant SHALL NOT affect q, w or the current transfer; a requester dropping req mid-transfer still receives ack.
REQ-021 A new req arriving during STROBE or ACK SHALL be considered only at the next IDLE.
REQ-022 The requester acked SHALL be de-asserted by the requester before the next IDLE edge if it has no further word; req still high in IDLE is a new request.

Reset
REQ-023 Asserting reset SHALL immediately force state=IDLE, q=0, strobe=0, ack=0, busy=0, counter=0 and round-robin pointer=0, including mid-transfer; the aborted requester receives no ack.
REQ-024 After reset release, the first grant SHALL occur no earlier than the first rising edge with reset low.

Configuration
REQ-025 Macro BUS_ARB_ROUND_ROBIN_EN defined: winner SHALL be the first asserted req scanning upward from (last winner+1) mod NREQ, pointer updated at each grant.
REQ-026 Macro BUS_ARB_ROUND_ROBIN_EN undefined: winner SHALL be the lowest asserted index (fixed priority); no pointer register.

Structure
REQ-027 Package bus_arb_pkg SHALL hold the FSM state encoding (IDLE=0, STROBE=1, ACK=2) and the counter width constant (4).
REQ-028 Winner selection SHALL be a combinational sub-module rr_pick (inputs req, pointer; outputs winner index, valid) instantiated once.
REQ-029 The q output register SHALL be the only register on the bus datapath.

Verification
REQ-030 Single: WIDTH=8, STROBE_CYCLES=2, req=0001, data0=8'hA5 -> q=A5 and strobe high for 2 cycles after grant edge, ack=0001 on the following cycle, busy low after.
REQ-031 Contention (RR enabled): req=1111 held, data i = 8'h10+i -> q sequence 10,11,12,13,10, each ack one-hot in the same order, 4 cycles per transfer.
REQ-032 Contention (RR disabled): req=0110 held -> q=11 repeatedly, ack=0010 every transfer; requester 2 never granted while requester 1 asserts.
REQ-033 Data change: grant req=0100 with data2=3C, change data2 to FF during strobe -> q stays 3C until next grant.
REQ-034 Reset mid-strobe: assert reset asynchronously in first strobe cycle -> q=00, strobe=0, ack never pulses, busy=0; after release, req=1000 grants requester 3 first.
REQ-035 Late request: req=0001 granted, req[2] rises during ACK -> requester 2 granted on the first IDLE edge, one cycle after ACK.
